// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: tagged sample/coefficient FIFO replayed in order as the FIR controller's dr/lc handshake.
// Optional watchdog on the DR/LCW waits is enabled by defining FEEDER_TIMEOUT_EN.
module fir_sample_feeder #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_is_coeff,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        modwait,
    input  logic                        err,
    output logic                        data_ready,
    output logic                        load_coeff,
    output logic [DATA_W-1:0]           sample_data,
    output logic [DATA_W-1:0]           fir_coefficient,
    output logic [1:0]                  coeff_idx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_flag,
    output logic                        timeout_flag
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DR    = 3'd1,
        S_LC    = 3'd2,
        S_LCW   = 3'd3,
        S_WAIT  = 3'd4,
        S_RECOV = 3'd5
    } state_t;

    state_t           state_r;
    logic [DATA_W:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [DATA_W:0]  head_s;
    logic             tmo_hit_s;

    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == FULL_CNT);
    assign in_ready   = !full_s;
    assign fifo_count = count_r;
    assign push_s     = in_valid && !full_s;
    assign head_s     = mem_r[rd_ptr_r];
    // An entry leaves the FIFO only when the FSM issues it from IDLE.
    assign pop_s      = (state_r == S_IDLE) && !err && !empty_s && !modwait;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Watchdog counts cycles spent waiting for modwait in DR/LCW.
    always_ff @(posedge clk) begin
        if (rst || !((state_r == S_DR) || (state_r == S_LCW))) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) && !modwait;
`else
    assign tmo_hit_s = 1'b0;
`endif

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(DATA_W + 1){1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {in_is_coeff, in_data};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Handshake FSM with registered dr/lc, datapath words and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            data_ready      <= 1'b0;
            load_coeff      <= 1'b0;
            sample_data     <= {DATA_W{1'b0}};
            fir_coefficient <= {DATA_W{1'b0}};
            coeff_idx       <= 2'd0;
            err_flag        <= 1'b0;
            timeout_flag    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (err) begin
                        err_flag   <= 1'b1;
                        data_ready <= 1'b1;
                        state_r    <= S_RECOV;
                    end else if (pop_s) begin
                        if (head_s[DATA_W]) begin
                            fir_coefficient <= head_s[DATA_W-1:0];
                            load_coeff      <= 1'b1;
                            state_r         <= S_LC;
                        end else begin
                            sample_data <= head_s[DATA_W-1:0];
                            data_ready  <= 1'b1;
                            state_r     <= S_DR;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_DR: begin
                    if (modwait) begin
                        data_ready <= 1'b0;
                        state_r    <= S_WAIT;
                    end else if (tmo_hit_s) begin
                        data_ready   <= 1'b0;
                        timeout_flag <= 1'b1;
                        state_r      <= S_IDLE;
                    end else begin
                        state_r <= S_DR;
                    end
                end
                // The controller faults if lc is seen twice, so it is a one-cycle pulse.
                S_LC: begin
                    load_coeff <= 1'b0;
                    coeff_idx  <= coeff_idx + 2'd1;
                    state_r    <= S_LCW;
                end
                S_LCW: begin
                    if (modwait) begin
                        state_r <= S_WAIT;
                    end else if (tmo_hit_s) begin
                        load_coeff   <= 1'b0;
                        timeout_flag <= 1'b1;
                        state_r      <= S_IDLE;
                    end else begin
                        state_r <= S_LCW;
                    end
                end
                S_WAIT: begin
                    if (err) begin
                        err_flag   <= 1'b1;
                        data_ready <= 1'b1;
                        state_r    <= S_RECOV;
                    end else if (!modwait) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                // One dr pulse kicks the controller out of error-idle; nothing is popped.
                S_RECOV: begin
                    data_ready <= 1'b0;
                    if (!err && !modwait) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_RECOV;
                    end
                end
                default: begin
                    data_ready <= 1'b0;
                    load_coeff <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: vector tables feed a scoreboard that a
// monitor drains as dr/lc issues appear; hand sequences cover full, error and reset cases.
module tb_fir_sample_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_coeff = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        modwait = 1'b0;
    logic        err = 1'b0;
    logic        data_ready;
    logic        load_coeff;
    logic [15:0] sample_data;
    logic [15:0] fir_coefficient;
    logic [1:0]  coeff_idx;
    logic [2:0]  fifo_count;
    logic        err_flag;
    logic        timeout_flag;

    fir_sample_feeder #(.DATA_W(16), .FIFO_DEPTH(4), .TIMEOUT_CYC(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_coeff(in_is_coeff), .in_data(in_data), .modwait(modwait), .err(err),
        .data_ready(data_ready), .load_coeff(load_coeff), .sample_data(sample_data),
        .fir_coefficient(fir_coefficient), .coeff_idx(coeff_idx), .fifo_count(fifo_count),
        .err_flag(err_flag), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_coeff;
        logic [15:0] data;
        logic [1:0]  exp_idx;
    } entry_t;

    entry_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    logic   ctl_auto = 1'b1;
    int     busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Controller model: sees dr/lc during a cycle, raises modwait after the next edge, busy 3 cycles.
    initial begin
        logic req;
        forever begin
            @(negedge clk);
            req = data_ready || load_coeff;
            @(posedge clk);
            #1;
            if (ctl_auto) begin
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) modwait = 1'b0;
                end else if (req) begin
                    modwait = 1'b1;
                    busy = 3;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each issue and checks held outputs every cycle.
    initial begin
        logic        prev_dr = 1'b0;
        logic        prev_lc = 1'b0;
        logic        tracking = 1'b0;
        int          run = 0;
        logic [15:0] exp_sample = 16'h0000;
        logic [15:0] exp_coef = 16'h0000;
        logic [1:0]  exp_idx = 2'd0;
        logic [1:0]  pend_idx = 2'd0;
        entry_t      e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_dr = 1'b0; prev_lc = 1'b0; tracking = 1'b0;
                exp_sample = 16'h0000; exp_coef = 16'h0000; exp_idx = 2'd0;
            end else begin
                if (prev_lc) exp_idx = pend_idx;
                if (data_ready && !prev_dr && !err) begin
                    tracking = 1'b1;
                    run = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dr_issue", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("issue_tag_dr", {31'd0, e.is_coeff}, 32'd0);
                        exp_sample = e.data;
                    end
                end else if (data_ready && tracking) begin
                    run++;
                end else if (!data_ready && prev_dr && tracking) begin
                    if (ctl_auto) chk("dr_len", run, 32'd2);
                    tracking = 1'b0;
                end
                if (load_coeff) begin
                    chk("lc_single", {31'd0, prev_lc}, 32'd0);
                    if (!prev_lc) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_lc_issue", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("issue_tag_lc", {31'd0, e.is_coeff}, 32'd1);
                            exp_coef = e.data;
                            pend_idx = e.exp_idx;
                        end
                    end
                end
                chk("sample_data", sample_data, exp_sample);
                chk("fir_coefficient", fir_coefficient, exp_coef);
                chk("coeff_idx", coeff_idx, exp_idx);
                prev_dr = data_ready;
                prev_lc = load_coeff;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic push_word(input entry_t e);
        int n = 0;
        in_valid = 1'b1;
        in_is_coeff = e.is_coeff;
        in_data = e.data;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_wait", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_count != 3'd0 || data_ready || load_coeff || modwait) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic wait_dr(input string name);
        int n = 0;
        while (!data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, data_ready}, 32'd1);
    endtask

    initial begin
        entry_t t3 [4];
        entry_t t4 [5];
        entry_t w;
        int     n;
        t3[0] = '{1'b1, 16'h0100, 2'd1};
        t3[1] = '{1'b1, 16'h0200, 2'd2};
        t3[2] = '{1'b1, 16'h0300, 2'd3};
        t3[3] = '{1'b1, 16'h0400, 2'd0};
        t4[0] = '{1'b0, 16'hA001, 2'd0};
        t4[1] = '{1'b1, 16'hC001, 2'd1};
        t4[2] = '{1'b0, 16'hA002, 2'd0};
        t4[3] = '{1'b1, 16'hC002, 2'd2};
        t4[4] = '{1'b0, 16'hA003, 2'd0};

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dr", {31'd0, data_ready}, 32'd0);
        chk("rst_lc", {31'd0, load_coeff}, 32'd0);
        chk("rst_sample", sample_data, 32'd0);
        chk("rst_coef", fir_coefficient, 32'd0);
        chk("rst_idx", coeff_idx, 32'd0);
        chk("rst_count", fifo_count, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_errf", {31'd0, err_flag}, 32'd0);
        chk("rst_tmof", {31'd0, timeout_flag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T2 single sample, latency and dr width
        w = '{1'b0, 16'h1234, 2'd0};
        push_word(w);
        chk("t2_lat_dr0", {31'd0, data_ready}, 32'd0);
        chk("t2_cnt1", fifo_count, 32'd1);
        @(negedge clk);
        chk("t2_lat_dr1", {31'd0, data_ready}, 32'd1);
        chk("t2_sample", sample_data, 32'h1234);
        chk("t2_cnt0", fifo_count, 32'd0);
        @(negedge clk);
        chk("t2_dr_cyc2", {31'd0, data_ready}, 32'd1);
        @(negedge clk);
        chk("t2_dr_low", {31'd0, data_ready}, 32'd0);
        drain("t2_drain");

        // T3 four coefficients
        for (int i = 0; i < 4; i++) push_word(t3[i]);
        drain("t3_drain");
        chk("t3_idx_wrap", coeff_idx, 32'd0);
        chk("t3_last_coef", fir_coefficient, 32'h0400);

        // T4 full FIFO with the controller stuck busy
        ctl_auto = 1'b0;
        modwait = 1'b1;
        for (int i = 0; i < 4; i++) push_word(t4[i]);
        chk("t4_full_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_full_cnt", fifo_count, 32'd4);
        in_valid = 1'b1;
        in_is_coeff = t4[4].is_coeff;
        in_data = t4[4].data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_cnt", fifo_count, 32'd4);
        end
        modwait = 1'b0;
        ctl_auto = 1'b1;
        push_word(t4[4]);
        drain("t4_drain");

        // T5 controller error while in WAIT
        ctl_auto = 1'b0;
        modwait = 1'b0;
        w = '{1'b0, 16'hB001, 2'd0};
        push_word(w);
        w = '{1'b0, 16'hB002, 2'd0};
        push_word(w);
        wait_dr("t5_dr_wait");
        @(posedge clk);
        #1 modwait = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_wait_dr", {31'd0, data_ready}, 32'd0);
        err = 1'b1;
        @(negedge clk);
        chk("t5_errflag", {31'd0, err_flag}, 32'd1);
        chk("t5_recov_dr", {31'd0, data_ready}, 32'd1);
        chk("t5_nopop", fifo_count, 32'd1);
        @(negedge clk);
        chk("t5_recov_dr_end", {31'd0, data_ready}, 32'd0);
        chk("t5_nopop2", fifo_count, 32'd1);
        err = 1'b0;
        modwait = 1'b0;
        ctl_auto = 1'b1;
        drain("t5_drain");
        chk("t5_errflag_sticky", {31'd0, err_flag}, 32'd1);

`ifdef FEEDER_TIMEOUT_EN
        // T6 watchdog: modwait never rises
        ctl_auto = 1'b0;
        modwait = 1'b0;
        w = '{1'b0, 16'hD001, 2'd0};
        push_word(w);
        w = '{1'b0, 16'hD002, 2'd0};
        push_word(w);
        wait_dr("t6_dr_wait");
        n = 0;
        while (data_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t6_dr_len", n, 32'd32);
        chk("t6_tmoflag", {31'd0, timeout_flag}, 32'd1);
        chk("t6_count", fifo_count, 32'd1);
        wait_dr("t6_dr2_wait");
        n = 0;
        while (data_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t6_dr2_len", n, 32'd32);
        ctl_auto = 1'b1;
        drain("t6_drain");
`else
        chk("tmoflag_off", {31'd0, timeout_flag}, 32'd0);
`endif

        // T7 reset in the middle of an issue
        w = '{1'b0, 16'hE001, 2'd0};
        push_word(w);
        w = '{1'b0, 16'hE002, 2'd0};
        push_word(w);
        wait_dr("t7_dr_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("t7_dr", {31'd0, data_ready}, 32'd0);
        chk("t7_count", fifo_count, 32'd0);
        chk("t7_ready", {31'd0, in_ready}, 32'd1);
        chk("t7_sample", sample_data, 32'd0);
        chk("t7_errflag", {31'd0, err_flag}, 32'd0);
        drain("t7_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
